// File: rtl/stream_unzip_if.sv
// Bundles the upstream push port and both pop-style downstream ports of stream_unzip.
// Latency: none, signal container only.
// Backpressure: full reflects the side that will take the next push; each side pops independently.
interface stream_unzip_if #(
    parameter int D_WIDTH = 6,
    parameter int DEPTH   = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [D_WIDTH-1:0] up_data;
    logic               push;
    logic               full;

    logic [D_WIDTH-1:0] down_data_a;
    logic               empty_a;
    logic               pop_a;
    logic [CW-1:0]      count_a;

    logic [D_WIDTH-1:0] down_data_b;
    logic               empty_b;
    logic               pop_b;
    logic [CW-1:0]      count_b;

    modport master (
        output up_data, push, pop_a, pop_b,
        input  full, down_data_a, empty_a, count_a, down_data_b, empty_b, count_b
    );

    modport slave (
        input  up_data, push, pop_a, pop_b,
        output full, down_data_a, empty_a, count_a, down_data_b, empty_b, count_b
    );
endinterface

// File: rtl/stream_unzip.sv
// Splits one pushed word stream alternately into two private FIFOs (A gets words 1,3,5..., B gets 2,4,6...).
// Latency: a word pushed at edge t is visible at its side's head just after edge t; outputs are registered-state only.
// Backpressure: a push to a full side is dropped and the steer bit holds; optional macro UNZIP_DROP_CNT_EN adds a saturating drop counter.

// Generic single-clock FIFO with head-word presentation and occupancy count.
module unzip_fifo #(
    parameter int  W     = 6,
    parameter int  DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_vld,
    input  logic [W-1:0]  wr_dat,
    input  logic          rd_rdy,
    output logic [W-1:0]  rd_dat,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count
);
    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          wr_ok;
    logic          rd_ok;

    // Full/empty come from the registered count, so a same-cycle pop never rescues a push.
    assign empty  = (count == '0);
    assign full   = (count == CW'(DEPTH));
    assign wr_ok  = wr_vld && !full;
    assign rd_ok  = rd_rdy && !empty;
    assign rd_dat = empty ? '0 : mem[rd_ptr];

    // Pointers wrap modulo DEPTH; the count disambiguates full from empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + PW'(1);
            if (rd_ok) rd_ptr <= rd_ptr + PW'(1);
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= wr_dat;
    end
endmodule

module stream_unzip #(
    parameter int D_WIDTH = 6,
    parameter int DEPTH   = 4
) (
    input  logic          clk,
    input  logic          rst,
    stream_unzip_if.slave bus
`ifdef UNZIP_DROP_CNT_EN
    ,
    output logic [7:0]    drop_cnt
`endif
);
    typedef enum logic {STEER_A = 1'b0, STEER_B = 1'b1} steer_t;

    steer_t steer;
    steer_t steer_nxt;
    logic   full_a;
    logic   full_b;
    logic   sel_full;
    logic   push_ok;
    logic   wr_a;
    logic   wr_b;

    assign sel_full = (steer == STEER_A) ? full_a : full_b;
    assign bus.full = sel_full;

    // Steer register: A after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) steer <= STEER_A;
        else     steer <= steer_nxt;
    end

    // Steer next-state and write enables: only an accepted push flips the steer, keeping A/B pairs aligned.
    always_comb begin
        steer_nxt = steer;
        push_ok   = bus.push && !sel_full;
        wr_a      = 1'b0;
        wr_b      = 1'b0;
        if (push_ok) begin
            if (steer == STEER_A) begin
                wr_a      = 1'b1;
                steer_nxt = STEER_B;
            end else begin
                wr_b      = 1'b1;
                steer_nxt = STEER_A;
            end
        end
    end

    unzip_fifo #(.W(D_WIDTH), .DEPTH(DEPTH)) u_fifo_a (
        .clk    (clk),
        .rst    (rst),
        .wr_vld (wr_a),
        .wr_dat (bus.up_data),
        .rd_rdy (bus.pop_a),
        .rd_dat (bus.down_data_a),
        .empty  (bus.empty_a),
        .full   (full_a),
        .count  (bus.count_a)
    );

    unzip_fifo #(.W(D_WIDTH), .DEPTH(DEPTH)) u_fifo_b (
        .clk    (clk),
        .rst    (rst),
        .wr_vld (wr_b),
        .wr_dat (bus.up_data),
        .rd_rdy (bus.pop_b),
        .rd_dat (bus.down_data_b),
        .empty  (bus.empty_b),
        .full   (full_b),
        .count  (bus.count_b)
    );

`ifdef UNZIP_DROP_CNT_EN
    // Count rejected pushes, saturating at 255.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                 drop_cnt <= 8'd0;
        else if (bus.push && sel_full && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
`endif
endmodule

// File: tb/tb_stream_unzip.sv
// Bench for stream_unzip: queue scoreboard per side plus directed checks.
// Inputs driven 1 ns after the rising edge, outputs sampled there too.
// Every comparison goes through chk.
module tb_stream_unzip;
    localparam int DW    = 6;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    stream_unzip_if #(.D_WIDTH(DW), .DEPTH(DEPTH)) bus ();
`ifdef UNZIP_DROP_CNT_EN
    logic [7:0] drop_cnt;
`endif

    stream_unzip #(.D_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
`ifdef UNZIP_DROP_CNT_EN
        ,
        .drop_cnt (drop_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] qa[$];
    logic [DW-1:0] qb[$];
    bit            m_steer;   // 0: next push to A
    int            m_drops;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_state();
        bit exp_full;
        exp_full = m_steer ? (qb.size() == DEPTH) : (qa.size() == DEPTH);
        chk("count_a", 32'(bus.count_a), 32'(qa.size()));
        chk("count_b", 32'(bus.count_b), 32'(qb.size()));
        chk("empty_a", 32'(bus.empty_a), 32'(qa.size() == 0));
        chk("empty_b", 32'(bus.empty_b), 32'(qb.size() == 0));
        chk("head_a", 32'(bus.down_data_a), (qa.size() != 0) ? 32'(qa[0]) : 32'd0);
        chk("head_b", 32'(bus.down_data_b), (qb.size() != 0) ? 32'(qb[0]) : 32'd0);
        chk("full", 32'(bus.full), 32'(exp_full));
`ifdef UNZIP_DROP_CNT_EN
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drops));
`endif
    endtask

    // One clock of stimulus; expected words enter the queues here and leave on pop.
    task automatic cycle(input bit p, input logic [DW-1:0] d, input bit pa, input bit pb);
        bit acc;
        bus.push    = p;
        bus.up_data = d;
        bus.pop_a   = pa;
        bus.pop_b   = pb;
        acc = p && ((m_steer ? qb.size() : qa.size()) < DEPTH);
        if (p && !acc && m_drops < 255) m_drops++;
        if (pa && qa.size() != 0) begin
            chk("pop_a_dat", 32'(bus.down_data_a), 32'(qa[0]));
            void'(qa.pop_front());
        end
        if (pb && qb.size() != 0) begin
            chk("pop_b_dat", 32'(bus.down_data_b), 32'(qb[0]));
            void'(qb.pop_front());
        end
        if (acc) begin
            if (m_steer) qb.push_back(d);
            else         qa.push_back(d);
            m_steer = !m_steer;
        end
        @(posedge clk);
        #1;
        bus.push  = 1'b0;
        bus.pop_a = 1'b0;
        bus.pop_b = 1'b0;
        check_state();
    endtask

    // Asynchronous reset asserted between edges; outputs must clear before any clock.
    task automatic reset_dut();
        #2;
        rst = 1'b1;
        #1;
        qa.delete();
        qb.delete();
        m_steer = 1'b0;
        m_drops = 0;
        chk("rst_count_a", 32'(bus.count_a), 0);
        chk("rst_empty_b", 32'(bus.empty_b), 1);
        chk("rst_full", 32'(bus.full), 0);
        chk("rst_head_a", 32'(bus.down_data_a), 0);
        chk("rst_head_b", 32'(bus.down_data_b), 0);
        check_state();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_state();
    endtask

    initial begin
        rst         = 1'b1;
        bus.push    = 1'b0;
        bus.up_data = '0;
        bus.pop_a   = 1'b0;
        bus.pop_b   = 1'b0;
        m_steer     = 1'b0;
        m_drops     = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("init_full", 32'(bus.full), 0);
        chk("init_empty_a", 32'(bus.empty_a), 1);
        chk("init_count_b", 32'(bus.count_b), 0);
        check_state();
        rst = 1'b0;

        // Alternating distribution, then paired pop.
        for (int i = 1; i <= 4; i++) cycle(1'b1, DW'(i), 1'b0, 1'b0);
        chk("t1_count_a", 32'(bus.count_a), 2);
        chk("t1_count_b", 32'(bus.count_b), 2);
        chk("t1_head_a", 32'(bus.down_data_a), 1);
        chk("t1_head_b", 32'(bus.down_data_b), 2);
        cycle(1'b0, '0, 1'b1, 1'b1);
        chk("t1_pop_head_a", 32'(bus.down_data_a), 3);
        chk("t1_pop_head_b", 32'(bus.down_data_b), 4);

        // Fill both sides, rejected push, recovery.
        reset_dut();
        for (int i = 10; i <= 17; i++) cycle(1'b1, DW'(i), 1'b0, 1'b0);
        chk("t2_full", 32'(bus.full), 1);
        chk("t2_count_a", 32'(bus.count_a), 4);
        chk("t2_count_b", 32'(bus.count_b), 4);
        cycle(1'b1, DW'(18), 1'b0, 1'b0);
        chk("t2_rej_count_a", 32'(bus.count_a), 4);
`ifdef UNZIP_DROP_CNT_EN
        chk("t2_drop_cnt", 32'(drop_cnt), 1);
`endif
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk("t2_popped_full", 32'(bus.full), 0);
        cycle(1'b1, DW'(19), 1'b0, 1'b0);
        chk("t2_19_count_a", 32'(bus.count_a), 4);
        chk("t2_next_b_full", 32'(bus.full), 1);
        cycle(1'b0, '0, 1'b0, 1'b1);
        cycle(1'b1, DW'(20), 1'b0, 1'b0);
        chk("t2_20_count_b", 32'(bus.count_b), 4);
        repeat (DEPTH + 1) cycle(1'b0, '0, 1'b1, 1'b1);

        // Pops on empty FIFOs, then push with simultaneous pop on empty A.
        reset_dut();
        repeat (3) cycle(1'b0, '0, 1'b1, 1'b1);
        chk("t3_count_a", 32'(bus.count_a), 0);
        chk("t3_head_b", 32'(bus.down_data_b), 0);
        chk("t3_empty_a", 32'(bus.empty_a), 1);
        cycle(1'b1, DW'(5), 1'b1, 1'b0);
        chk("t3_push_count_a", 32'(bus.count_a), 1);
        chk("t3_push_head_a", 32'(bus.down_data_a), 5);

        // Push and pop together on a partially filled A.
        reset_dut();
        for (int i = 0; i < 6; i++) cycle(1'b1, DW'(20 + i), 1'b0, 1'b0);
        chk("t4_count_a", 32'(bus.count_a), 3);
        cycle(1'b1, DW'(26), 1'b1, 1'b0);
        chk("t4_pp_count_a", 32'(bus.count_a), 3);
        chk("t4_pp_head_a", 32'(bus.down_data_a), 22);
        repeat (DEPTH + 1) cycle(1'b0, '0, 1'b1, 1'b1);

        // Continuous streaming across pointer wrap.
        reset_dut();
        for (int i = 0; i < 2 * 3 * DEPTH; i++)
            cycle(1'b1, DW'($urandom_range(0, 63)), i >= 2, i >= 3);
        repeat (DEPTH + 1) cycle(1'b0, '0, 1'b1, 1'b1);

        // Mid-stream reset with both sides half full.
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, DW'(40 + i), 1'b0, 1'b0);
        chk("t6_pre_count_a", 32'(bus.count_a), DEPTH / 2);
        reset_dut();
        cycle(1'b1, DW'(7), 1'b0, 1'b0);
        chk("t6_head_a", 32'(bus.down_data_a), 7);
        chk("t6_count_a", 32'(bus.count_a), 1);
        chk("t6_empty_b", 32'(bus.empty_b), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
